// File: rtl/xpoint_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xpoint_stage_if                                         |
// | Description : Lane inputs, crosspoint-facing output word and status   |
// |               for the crosspoint input stage.                         |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface xpoint_stage_if #(
  parameter int FLIT_SIZE = 64,
  parameter int CNT_W     = 16
);
  logic                 h_in_valid;
  logic [FLIT_SIZE-1:0] h_in_flit;
  logic                 h_in_ready;
  logic                 v_in_valid;
  logic [FLIT_SIZE-1:0] v_in_flit;
  logic                 v_in_ready;
  logic [FLIT_SIZE-1:0] h_out;
  logic [FLIT_SIZE-1:0] v_out;
  logic                 h_out_valid;
  logic                 v_out_valid;
  logic                 cross_enable;
  logic                 out_ready;
  logic [CNT_W-1:0]     conflict_cnt;

  // Traffic source / sink side
  modport master (
    output h_in_valid, h_in_flit, v_in_valid, v_in_flit, out_ready,
    input  h_in_ready, v_in_ready, h_out, v_out, h_out_valid, v_out_valid,
           cross_enable, conflict_cnt
  );

  // Stage side
  modport slave (
    input  h_in_valid, h_in_flit, v_in_valid, v_in_flit, out_ready,
    output h_in_ready, v_in_ready, h_out, v_out, h_out_valid, v_out_valid,
           cross_enable, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/xpoint_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xpoint_stage                                            |
// | Description : One-flit head buffer per lane feeding a registered      |
// |               {h_flit, v_flit, cross_enable} word to the crosspoint.  |
// |               Conflicting turn requests are resolved round-robin.     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module xpoint_stage #(
  parameter int FLIT_SIZE = 64,
  parameter int TURN_BIT  = 63,
  parameter int CNT_W     = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  xpoint_stage_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Head buffers
  logic [FLIT_SIZE-1:0] r_hd_h;
  logic [FLIT_SIZE-1:0] r_hd_v;
  logic                 r_hd_h_valid;
  logic                 r_hd_v_valid;

  // Output word
  logic [FLIT_SIZE-1:0] r_h_out;
  logic [FLIT_SIZE-1:0] r_v_out;
  logic                 r_h_out_valid;
  logic                 r_v_out_valid;
  logic                 r_cross;

  // Arbitration state: 0 gives the horizontal lane priority on a conflict
  logic                 r_rr;
  logic [CNT_W-1:0]     r_cnt;

  logic w_out_free;
  logic w_t_h;
  logic w_t_v;
  logic w_conflict;
  logic w_launch_h;
  logic w_launch_v;
  logic w_cross_nxt;
  logic w_acc_h;
  logic w_acc_v;

  // The output word may be replaced when it is empty or being consumed now
  assign w_out_free = !(r_h_out_valid | r_v_out_valid) | bus.out_ready;
  assign w_t_h      = r_hd_h[TURN_BIT];
  assign w_t_v      = r_hd_v[TURN_BIT];
  assign w_conflict = r_hd_h_valid & r_hd_v_valid & (w_t_h != w_t_v);

  // On a conflict only the round-robin winner leaves its head
  assign w_launch_h = w_out_free & r_hd_h_valid & (!w_conflict | !r_rr);
  assign w_launch_v = w_out_free & r_hd_v_valid & (!w_conflict |  r_rr);

  // Launched lanes always agree on the turn bit, so either one sets the switch
  assign w_cross_nxt = w_launch_h ? w_t_h : (w_launch_v ? w_t_v : 1'b0);

  // A head can take a new flit while its current one is leaving
  assign bus.h_in_ready = !r_hd_h_valid | w_launch_h;
  assign bus.v_in_ready = !r_hd_v_valid | w_launch_v;
  assign w_acc_h        = bus.h_in_valid & bus.h_in_ready;
  assign w_acc_v        = bus.v_in_valid & bus.v_in_ready;

  assign bus.h_out        = r_h_out;
  assign bus.v_out        = r_v_out;
  assign bus.h_out_valid  = r_h_out_valid;
  assign bus.v_out_valid  = r_v_out_valid;
  assign bus.cross_enable = r_cross;
  assign bus.conflict_cnt = r_cnt;

  // Head buffers: refill on accept, drain on launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hd_h       <= '0;
      r_hd_v       <= '0;
      r_hd_h_valid <= 1'b0;
      r_hd_v_valid <= 1'b0;
    end else begin
      if (w_acc_h) begin
        r_hd_h       <= bus.h_in_flit;
        r_hd_h_valid <= 1'b1;
      end else if (w_launch_h) begin
        r_hd_h_valid <= 1'b0;
      end
      if (w_acc_v) begin
        r_hd_v       <= bus.v_in_flit;
        r_hd_v_valid <= 1'b1;
      end else if (w_launch_v) begin
        r_hd_v_valid <= 1'b0;
      end
    end
  end

  // Output word: reloaded with launched flits (zeros for idle lanes) when free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_out       <= '0;
      r_v_out       <= '0;
      r_h_out_valid <= 1'b0;
      r_v_out_valid <= 1'b0;
      r_cross       <= 1'b0;
    end else if (w_out_free) begin
      r_h_out       <= w_launch_h ? r_hd_h : '0;
      r_v_out       <= w_launch_v ? r_hd_v : '0;
      r_h_out_valid <= w_launch_h;
      r_v_out_valid <= w_launch_v;
      r_cross       <= w_cross_nxt;
    end
  end

  // Round-robin pointer hands priority to the loser; conflicts are counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr  <= 1'b0;
      r_cnt <= '0;
    end else if (w_out_free && w_conflict) begin
      r_rr <= !r_rr;
      if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xpoint_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_xpoint_stage                                         |
// | Description : Randomised and directed bench for xpoint_stage against  |
// |               a queue-based lane model.                               |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_xpoint_stage;
  localparam int c_fs   = 64;
  localparam int c_tb   = 63;
  localparam int c_cw   = 4;
  localparam int c_cmax = (1 << c_cw) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  xpoint_stage_if #(.FLIT_SIZE(c_fs), .CNT_W(c_cw)) bus ();

  xpoint_stage #(.FLIT_SIZE(c_fs), .TURN_BIT(c_tb), .CNT_W(c_cw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: each lane head is a queue of at most one flit; output word as plain values
  logic [c_fs-1:0] mh[$];
  logic [c_fs-1:0] mv[$];
  logic [c_fs-1:0] m_h_out, m_v_out;
  logic            m_hv, m_vv, m_ce, m_rr;
  int              m_cnt;

  task automatic chk(string nm, logic [c_fs-1:0] act, logic [c_fs-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which heads leave this cycle, from the current model contents
  function automatic void m_decide(output logic lh, output logic lv, output logic conf);
    logic free, th, tv, hok, vok;
    free = !(m_hv || m_vv) || bus.out_ready;
    hok  = mh.size() > 0;
    vok  = mv.size() > 0;
    th   = hok ? mh[0][c_tb] : 1'b0;
    tv   = vok ? mv[0][c_tb] : 1'b0;
    conf = hok && vok && (th != tv);
    if (!free) begin
      lh = 1'b0; lv = 1'b0;
    end else if (conf) begin
      lh = !m_rr; lv = m_rr;
    end else begin
      lh = hok; lv = vok;
    end
  endfunction

  // Model state advance
  always @(posedge clk or negedge rst_n) begin : model
    logic lh, lv, cf, rh, rv, free;
    if (!rst_n) begin
      mh.delete(); mv.delete();
      m_h_out = '0; m_v_out = '0; m_hv = 0; m_vv = 0; m_ce = 0; m_rr = 0; m_cnt = 0;
    end else begin
      free = !(m_hv || m_vv) || bus.out_ready;
      m_decide(lh, lv, cf);
      rh = (mh.size() == 0) || lh;
      rv = (mv.size() == 0) || lv;
      if (free) begin
        m_h_out = lh ? mh[0] : '0;
        m_v_out = lv ? mv[0] : '0;
        m_hv = lh; m_vv = lv;
        m_ce = lh ? m_h_out[c_tb] : (lv ? m_v_out[c_tb] : 1'b0);
        if (cf) begin
          m_rr = !m_rr;
          if (m_cnt < c_cmax) m_cnt++;
        end
      end
      if (lh) void'(mh.pop_front());
      if (lv) void'(mv.pop_front());
      if (bus.h_in_valid && rh) mh.push_back(bus.h_in_flit);
      if (bus.v_in_valid && rv) mv.push_back(bus.v_in_flit);
    end
  end

  // Compare process: every output against the model each cycle
  always @(negedge clk) begin : compare
    logic lh, lv, cf;
    m_decide(lh, lv, cf);
    chk("h_out", bus.h_out, m_h_out);
    chk("v_out", bus.v_out, m_v_out);
    chk("h_out_valid", 64'(bus.h_out_valid), 64'(m_hv));
    chk("v_out_valid", 64'(bus.v_out_valid), 64'(m_vv));
    chk("cross_enable", 64'(bus.cross_enable), 64'(m_ce));
    chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
    chk("h_in_ready", 64'(bus.h_in_ready), 64'((mh.size() == 0) || lh));
    chk("v_in_ready", 64'(bus.v_in_ready), 64'((mv.size() == 0) || lv));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted and released mid-cycle
  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.h_in_valid = 0;
    bus.v_in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_h_out", bus.h_out, '0);
    chk("rst_v_out", bus.v_out, '0);
    chk("rst_valids", 64'({bus.h_out_valid, bus.v_out_valid}), 64'd0);
    chk("rst_cross", 64'(bus.cross_enable), 64'd0);
    chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1;
    #1;
    chk("rst_in_ready", 64'({bus.h_in_ready, bus.v_in_ready}), 64'b11);
  endtask

  task automatic drive(logic hv, logic [c_fs-1:0] hf, logic vv, logic [c_fs-1:0] vf);
    bus.h_in_valid = hv; bus.h_in_flit = hf;
    bus.v_in_valid = vv; bus.v_in_flit = vf;
  endtask

  initial begin : stim
    logic [c_fs-1:0] hold_h, hold_v;
    drive(0, '0, 0, '0);
    bus.out_ready = 1;
    #12;
    rst_n = 1;

    // Straight pair, then crossing pair
    do_reset();
    drive(1, 64'hA1, 1, 64'hB2);
    step();
    drive(0, '0, 0, '0);
    step();
    chk("pair_h_out", bus.h_out, 64'hA1);
    chk("pair_v_out", bus.v_out, 64'hB2);
    chk("pair_valid", 64'({bus.h_out_valid, bus.v_out_valid}), 64'b11);
    chk("pair_cross0", 64'(bus.cross_enable), 64'd0);
    drive(1, {1'b1, 63'hA1}, 1, {1'b1, 63'hB2});
    step();
    drive(0, '0, 0, '0);
    step();
    chk("xpair_valid", 64'({bus.h_out_valid, bus.v_out_valid}), 64'b11);
    chk("xpair_cross1", 64'(bus.cross_enable), 64'd1);
    chk("xpair_v_out", bus.v_out, {1'b1, 63'hB2});

    // Single conflict: h turns, v straight, h wins first
    do_reset();
    drive(1, {1'b1, 63'hC3}, 1, 64'hD4);
    step();
    drive(0, '0, 0, '0);
    step();
    chk("cf_h_out", bus.h_out, {1'b1, 63'hC3});
    chk("cf_valid", 64'({bus.h_out_valid, bus.v_out_valid}), 64'b10);
    chk("cf_cross", 64'(bus.cross_enable), 64'd1);
    chk("cf_cnt", 64'(bus.conflict_cnt), 64'd1);
    bus.out_ready = 0;
    #1;
    chk("cf_v_held", 64'(bus.v_in_ready), 64'd0);
    bus.out_ready = 1;
    step();
    chk("cf2_v_out", bus.v_out, 64'hD4);
    chk("cf2_valid", 64'({bus.h_out_valid, bus.v_out_valid}), 64'b01);
    chk("cf2_cross", 64'(bus.cross_enable), 64'd0);

    // Alternating conflicts with both lanes always offered
    do_reset();
    drive(1, {1'b1, 63'h100}, 1, 64'h200);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1, {1'b1, 63'(64'h101 + i)}, 1, 64'(64'h201 + i));
      step();
      chk("alt_winner", 64'({bus.h_out_valid, bus.v_out_valid}), (i % 2 == 0) ? 64'b10 : 64'b01);
    end
    chk("alt_cnt", 64'(bus.conflict_cnt), 64'd6);
    drive(0, '0, 0, '0);

    // Backpressure with the output word full
    do_reset();
    drive(1, 64'h11, 1, 64'h22);
    step();
    drive(1, 64'h33, 1, 64'h44);
    step();
    bus.out_ready = 0;
    hold_h = bus.h_out;
    hold_v = bus.v_out;
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(64'h50 + i), 1, 64'(64'h60 + i));
      step();
    end
    chk("bp_h_stable", bus.h_out, hold_h);
    chk("bp_v_stable", bus.v_out, hold_v);
    chk("bp_h_lit", hold_h, 64'h11);
    chk("bp_in_ready", 64'({bus.h_in_ready, bus.v_in_ready}), 64'b00);
    drive(0, '0, 0, '0);
    bus.out_ready = 1;
    step();
    chk("bp_drain1", bus.h_out, 64'h33);
    repeat (3) step();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, {1'b1, 63'(i)}, 1, 64'(i));
      step();
    end
    step();
    chk("sat_cnt", 64'(bus.conflict_cnt), 64'd15);
    drive(0, '0, 0, '0);

    // Randomised traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
            $urandom_range(0, 3) != 0, {$urandom, $urandom});
      bus.out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drive(0, '0, 0, '0);
    bus.out_ready = 1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
